// File: rtl/id_operand_stage.sv
// Decode-stage operand selection, hazard detection and ID->EX pipeline register.
// Optional feature macro: FORWARDING_EN (EX/MEM forwarding; undefined = stall until WB bypass).
module id_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_ID_valid,
    input  logic [4:0]  IF_ID_rs1,
    input  logic [4:0]  IF_ID_rs2,
    input  logic [4:0]  IF_ID_rd,
    input  logic        IF_ID_rd_we,
    input  logic        IF_ID_is_load,
    output logic [4:0]  ID_EX_rs1,
    output logic [4:0]  ID_EX_rs2,
    input  logic [31:0] RF_rs1_data,
    input  logic [31:0] RF_rs2_data,
    input  logic [31:0] EX_result,
    input  logic [4:0]  MEM_rd,
    input  logic        MEM_we,
    input  logic [31:0] MEM_data,
    input  logic [4:0]  WB_rd,
    input  logic        WB_we,
    input  logic [31:0] WB_data,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        ID_stall,
    output logic        EX_valid,
    output logic [4:0]  EX_rd,
    output logic        EX_rd_we,
    output logic        EX_is_load,
    output logic [31:0] EX_rs1_val,
    output logic [31:0] EX_rs2_val,
    output logic [15:0] hazard_cnt
);

    logic        valid_q, valid_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d;
    logic        is_load_q, is_load_d;
    logic [31:0] rs1_val_q, rs1_val_d;
    logic [31:0] rs2_val_q, rs2_val_d;
    logic [15:0] cnt_q, cnt_d;

    logic        rs1_nz, rs2_nz;
    logic        ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic [31:0] op1, op2;
    logic        hazard;

    assign ID_EX_rs1 = IF_ID_rs1;
    assign ID_EX_rs2 = IF_ID_rs2;

    assign rs1_nz = (IF_ID_rs1 != 5'd0);
    assign rs2_nz = (IF_ID_rs2 != 5'd0);

    assign mem_m1 = MEM_we && (MEM_rd == IF_ID_rs1) && rs1_nz;
    assign mem_m2 = MEM_we && (MEM_rd == IF_ID_rs2) && rs2_nz;
    assign wb_m1  = WB_we  && (WB_rd  == IF_ID_rs1) && rs1_nz;
    assign wb_m2  = WB_we  && (WB_rd  == IF_ID_rs2) && rs2_nz;

`ifdef FORWARDING_EN
    // Loads are excluded: their data is not ready until MEM.
    assign ex_m1 = valid_q && rd_we_q && !is_load_q && (rd_q == IF_ID_rs1) && rs1_nz;
    assign ex_m2 = valid_q && rd_we_q && !is_load_q && (rd_q == IF_ID_rs2) && rs2_nz;

    assign op1 = !rs1_nz ? 32'd0 : ex_m1 ? EX_result : mem_m1 ? MEM_data :
                 wb_m1 ? WB_data : RF_rs1_data;
    assign op2 = !rs2_nz ? 32'd0 : ex_m2 ? EX_result : mem_m2 ? MEM_data :
                 wb_m2 ? WB_data : RF_rs2_data;

    assign hazard = IF_ID_valid && valid_q && is_load_q && rd_we_q && (rd_q != 5'd0) &&
                    ((rd_q == IF_ID_rs1) || (rd_q == IF_ID_rs2));
`else
    logic unused_fwd;
    assign unused_fwd = ^{EX_result, MEM_data};

    // Any in-flight writer of a source blocks ID until it reaches WB.
    assign ex_m1 = valid_q && rd_we_q && (rd_q == IF_ID_rs1) && rs1_nz;
    assign ex_m2 = valid_q && rd_we_q && (rd_q == IF_ID_rs2) && rs2_nz;

    assign op1 = !rs1_nz ? 32'd0 : wb_m1 ? WB_data : RF_rs1_data;
    assign op2 = !rs2_nz ? 32'd0 : wb_m2 ? WB_data : RF_rs2_data;

    assign hazard = IF_ID_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
`endif

    assign ID_stall = !flush && (hazard || !ex_ready);

    always_comb begin
        valid_d   = valid_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        is_load_d = is_load_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        cnt_d     = cnt_q;
        if (hazard && !flush && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ex_ready) begin
            if (hazard) begin
                valid_d = 1'b0;
            end else begin
                valid_d   = IF_ID_valid;
                rd_d      = IF_ID_rd;
                rd_we_d   = IF_ID_rd_we;
                is_load_d = IF_ID_is_load;
                rs1_val_d = op1;
                rs2_val_d = op2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            rd_q      <= 5'd0;
            rd_we_q   <= 1'b0;
            is_load_q <= 1'b0;
            rs1_val_q <= 32'd0;
            rs2_val_q <= 32'd0;
            cnt_q     <= 16'd0;
        end else begin
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            is_load_q <= is_load_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            cnt_q     <= cnt_d;
        end
    end

    assign EX_valid   = valid_q;
    assign EX_rd      = rd_q;
    assign EX_rd_we   = rd_we_q;
    assign EX_is_load = is_load_q;
    assign EX_rs1_val = rs1_val_q;
    assign EX_rs2_val = rs2_val_q;
    assign hazard_cnt = cnt_q;

endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset.
REQ-003 IF_ID_valid / IF_ID_rs1,rs2,rd[4:0] / IF_ID_rd_we / IF_ID_is_load  input  decoded instruction in ID.
REQ-004 ID_EX_rs1, ID_EX_rs2  output  5  register-file read addresses; combinationally equal to IF_ID_rs1/rs2.
REQ-005 RF_rs1_data, RF_rs2_data  input  32  register-file read data for ID_EX_rs1/rs2.
REQ-006 EX_result  input  32  ALU result of the instruction held in this block's output register.
REQ-007 MEM_rd[4:0], MEM_we, MEM_data[31:0]  input  instruction in MEM stage; MEM_data final, including loads.
REQ-008 WB_rd[4:0], WB_we, WB_data[31:0]  input  same signals driven to the register file write port.
REQ-009 ex_ready  input  1  EX accepts a new instruction this cycle.
REQ-010 flush  input  1  discard the ID instruction and the output register.
REQ-011 ID_stall  output  1  IF/ID holds its instruction this cycle.
REQ-012 EX_valid, EX_rd[4:0], EX_rd_we, EX_is_load, EX_rs1_val[31:0], EX_rs2_val[31:0]  output  registered operand bundle to EX.
REQ-013 hazard_cnt  output  16  saturating count of cycles with a hazard stall.

Function
REQ-014 Operand select per source, priority order: register 0 -> 0; EX match -> EX_result; MEM match -> MEM_data; WB match -> WB_data; else RF data.
REQ-015 EX match = EX_valid & EX_rd_we & !EX_is_load & EX_rd==rs; MEM match = MEM_we & MEM_rd==rs; WB match = WB_we & WB_rd==rs; rs != 0 in all cases.
REQ-016 WB bypass compensates for the register file's write-then-read timing and is always present, independent of configuration.
REQ-017 Hazard = IF_ID_valid & EX_valid & EX_is_load & EX_rd_we & EX_rd!=0 & EX_rd matches rs1 or rs2.
REQ-018 ID_stall = hazard | !ex_ready, combinational; deasserted while flush=1.
REQ-019 Capture: ex_ready=1, no hazard, no flush -> output register loads the selected operands and the IF_ID fields; EX_valid <= IF_ID_valid.
REQ-020 Bubble: ex_ready=1 with hazard -> EX_valid <= 0; the other output fields are don't-care.
REQ-021 Hold: ex_ready=0 -> all output fields unchanged; no capture, no bubble.
REQ-022 Flush: flush=1 -> EX_valid <= 0 next edge, overriding hold, hazard and capture.
REQ-023 A load-use stall lasts exactly 1 cycle; on the next cycle the load is in MEM and its value is forwarded via REQ-014.
REQ-024 hazard_cnt increments on each cycle where hazard=1 and flush=0; it saturates at 16'hFFFF and does not wrap.
REQ-025 Latency ID -> EX output: 1 cycle when unstalled.

Reset
REQ-026 rst=0 at a rising edge -> EX_valid=0, EX_rd=0, EX_rd_we=0, EX_is_load=0, EX_rs1_val=0, EX_rs2_val=0, hazard_cnt=0.
REQ-027 Reset overrides flush, hold and capture; an instruction stalled mid-hazard is dropped.
REQ-028 ID_stall is combinational and is not forced by reset.

Configuration
REQ-029 Macro FORWARDING_EN defined: behaviour exactly as REQ-014..REQ-024.
REQ-030 FORWARDING_EN undefined: the EX and MEM forwarding paths are removed; the WB bypass remains.
REQ-031 FORWARDING_EN undefined: hazard = any EX match (loads included) or MEM match on a used rs, giving a stall of up to 2 cycles; hazard_cnt counts these stalls.

Verification
REQ-032 EX holds addi x5 (EX_result=0x10), ID reads rs1=x5 -> next cycle EX_rs1_val=0x10, EX_valid=1, no stall.
REQ-033 EX holds lw x6, ID uses x6 -> ID_stall=1 for 1 cycle, bubble inserted, then EX_rs2_val=MEM_data=0xDEADBEEF; hazard_cnt=1.
REQ-034 WB_we=1, WB_rd=x7, WB_data=0x55, RF returns stale 0, ID reads x7 -> EX_rs1_val=0x55; with rs=x0 and WB_rd=0 -> operand 0.
REQ-035 ex_ready=0 for 3 cycles -> outputs held; flush asserted in cycle 2 -> EX_valid=0 next edge.
REQ-036 rst=0 while a hazard is active -> all outputs 0 next edge; 70000 hazard cycles -> hazard_cnt=0xFFFF.
REQ-037 FORWARDING_EN undefined, back-to-back dependent addi -> 2 stall cycles, then operand taken from WB bypass.
